sysarray8_feeder: RTL and testbench

Upstream operand feeder for the 8x8 systolic multiplier. It buffers one 8x8 matrix A and one 8x8 matrix B of 32-bit words, loaded through a simple write port. On `start` it streams them into the array's west and north edges with the diagonal skew the array requires. It then holds the edges at zero for a drain window and pulses `done`, so the downstream array sees a complete, aligned wavefront with no external sequencing.

---
 rtl/sysarray_pkg.sv | 22 ++
 rtl/mat_buf8.sv | 50 +++++
 rtl/sysarray8_feeder.sv | 162 ++++++++++++++++
 tb/tb_sysarray8_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sysarray_pkg.sv
// Shared constants and types for the 8x8 systolic array operand feeder.
package sysarray_pkg;

    localparam int SA_N            = 8;
    localparam int SA_DW           = 32;
    localparam int SA_DRAIN_CYCLES = 8;
    localparam int SA_ADDR_W       = $clog2(SA_N * SA_N);

    // Width of a counter that spans the skewed feed plus the drain window.
    function automatic int step_cnt_w(input int n, input int drain);
        return $clog2(2 * n - 1 + drain);
    endfunction

    localparam int SA_CNT_W = step_cnt_w(SA_N, SA_DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/mat_buf8.sv
// N x N word buffer with one write port and N skewed combinational read lanes.
// LANE_IS_ROW=1: lane l at step t returns M[l][t-l] (west feed of A).
// LANE_IS_ROW=0: lane l at step t returns M[t-l][l] (north feed of B).
// Lanes outside their window 0 <= t-l < N return zero.
module mat_buf8
    import sysarray_pkg::*;
#(
    parameter int N           = SA_N,
    parameter int DW          = SA_DW,
    parameter int STEP_W      = SA_CNT_W,
    parameter bit LANE_IS_ROW = 1'b1
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [$clog2(N*N)-1:0]    waddr_i,
    input  logic [DW-1:0]             wdata_i,
    input  logic [STEP_W-1:0]         step_i,
    output logic [N-1:0][DW-1:0]      lane_o
);

    localparam int AW = $clog2(N * N);

    // Storage is deliberately not reset so contents survive a reset.
    logic [DW-1:0] mem_q [N*N];

    // Word write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Skewed read: each lane picks the diagonal element for the current step.
    always_comb begin
        int k;
        k = 0;
        for (int l = 0; l < N; l++) begin
            lane_o[l] = '0;
            if ((int'(step_i) >= l) && (int'(step_i) - l < N)) begin
                k = int'(step_i) - l;
                if (LANE_IS_ROW) begin
                    lane_o[l] = mem_q[AW'(l * N + k)];
                end else begin
                    lane_o[l] = mem_q[AW'(k * N + l)];
                end
            end
        end
    end

endmodule

// File: rtl/sysarray8_feeder.sv
// Operand feeder for the 8x8 systolic multiplier: buffers A and B, then
// streams them with diagonal skew onto the west/north edges, drains with
// zeros and pulses done.
module sysarray8_feeder
    import sysarray_pkg::*;
#(
    parameter int N            = SA_N,
    parameter int DW           = SA_DW,
    parameter int DRAIN_CYCLES = SA_DRAIN_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [$clog2(N*N)-1:0]  wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    start,
    output logic [DW-1:0]           west0,
    output logic [DW-1:0]           west1,
    output logic [DW-1:0]           west2,
    output logic [DW-1:0]           west3,
    output logic [DW-1:0]           west4,
    output logic [DW-1:0]           west5,
    output logic [DW-1:0]           west6,
    output logic [DW-1:0]           west7,
    output logic [DW-1:0]           north0,
    output logic [DW-1:0]           north1,
    output logic [DW-1:0]           north2,
    output logic [DW-1:0]           north3,
    output logic [DW-1:0]           north4,
    output logic [DW-1:0]           north5,
    output logic [DW-1:0]           north6,
    output logic [DW-1:0]           north7,
    output logic                    busy,
    output logic                    done
);

    localparam int FEED_STEPS = 2 * N - 1;
    localparam int LAST_STEP  = FEED_STEPS + DRAIN_CYCLES - 1;
    localparam int CW         = step_cnt_w(N, DRAIN_CYCLES);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [N-1:0][DW-1:0]   west_q, west_d;
    logic [N-1:0][DW-1:0]   north_q, north_d;
    logic [N-1:0][DW-1:0]   a_lane, b_lane;
    logic                   a_we, b_we;

    // Buffers only accept writes while idle and out of reset.
    assign a_we = wr_en && rst && (state_q == IDLE) && !wr_sel;
    assign b_we = wr_en && rst && (state_q == IDLE) &&  wr_sel;

    // The read step is the next counter value, so the lanes registered on an
    // edge are exactly the step shown in the following cycle. On the
    // start-accept edge this reads the pre-write buffer contents.
    mat_buf8 #(
        .N           (N),
        .DW          (DW),
        .STEP_W      (CW),
        .LANE_IS_ROW (1'b1)
    ) u_buf_a (
        .clk     (clk),
        .we_i    (a_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .step_i  (cnt_d),
        .lane_o  (a_lane)
    );

    mat_buf8 #(
        .N           (N),
        .DW          (DW),
        .STEP_W      (CW),
        .LANE_IS_ROW (1'b0)
    ) u_buf_b (
        .clk     (clk),
        .we_i    (b_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .step_i  (cnt_d),
        .lane_o  (b_lane)
    );

    // Next-state logic: one counter runs across feed and drain; state_q
    // always describes what the output registers currently present.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (cnt_q == CW'(FEED_STEPS - 1)) begin
                    state_d = DRAIN;
                end
                cnt_d = cnt_q + 1'b1;
            end
            DRAIN: begin
                if (cnt_q == CW'(LAST_STEP)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d  = (state_d != IDLE);
        west_d  = (state_d == FEED) ? a_lane : '0;
        north_d = (state_d == FEED) ? b_lane : '0;
    end

    // State, counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            west_q  <= '0;
            north_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign west0  = west_q[0];
    assign west1  = west_q[1];
    assign west2  = west_q[2];
    assign west3  = west_q[3];
    assign west4  = west_q[4];
    assign west5  = west_q[5];
    assign west6  = west_q[6];
    assign west7  = west_q[7];
    assign north0 = north_q[0];
    assign north1 = north_q[1];
    assign north2 = north_q[2];
    assign north3 = north_q[3];
    assign north4 = north_q[4];
    assign north5 = north_q[5];
    assign north6 = north_q[6];
    assign north7 = north_q[7];

endmodule

// File: tb/tb_sysarray8_feeder.sv
// Directed bench for sysarray8_feeder.
`timescale 1ns/1ps
module tb_sysarray8_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic [31:0] west0, west1, west2, west3, west4, west5, west6, west7;
    logic [31:0] north0, north1, north2, north3, north4, north5, north6, north7;
    logic        busy, done;

    logic [31:0] w [8];
    logic [31:0] n [8];

    logic [31:0] ref_a [64];
    logic [31:0] ref_b [64];
    logic [31:0] obs_w [8][23];
    logic [31:0] obs_n [8][23];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sysarray8_feeder dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .west0   (west0),
        .west1   (west1),
        .west2   (west2),
        .west3   (west3),
        .west4   (west4),
        .west5   (west5),
        .west6   (west6),
        .west7   (west7),
        .north0  (north0),
        .north1  (north1),
        .north2  (north2),
        .north3  (north3),
        .north4  (north4),
        .north5  (north5),
        .north6  (north6),
        .north7  (north7),
        .busy    (busy),
        .done    (done)
    );

    assign w[0] = west0;  assign w[1] = west1;  assign w[2] = west2;  assign w[3] = west3;
    assign w[4] = west4;  assign w[5] = west5;  assign w[6] = west6;  assign w[7] = west7;
    assign n[0] = north0; assign n[1] = north1; assign n[2] = north2; assign n[3] = north3;
    assign n[4] = north4; assign n[5] = north5; assign n[6] = north6; assign n[7] = north7;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_w(input int i, input int t);
        if (t < 15 && t >= i && t - i < 8) return ref_a[i*8 + (t - i)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_n(input int j, input int t);
        if (t < 15 && t >= j && t - j < 8) return ref_b[(t - j)*8 + j];
        return 32'h0;
    endfunction

    // One buffer write, issued at a falling edge.
    task automatic wr(input bit sel, input int addr, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 6'(addr);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) ref_b[addr] = d; else ref_a[addr] = d;
    endtask

    task automatic check_idle_outputs(input string nm);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s west%0d", nm, i), w[i], 32'h0);
            check($sformatf("%s north%0d", nm, i), n[i], 32'h0);
        end
    endtask

    // Raises start at the current falling edge and checks every cycle of the
    // run. inj_step: step at which a busy-time write+start is attempted.
    // rst_step: step at which reset is asserted (run aborts).
    // wr_same: write A[0]=wr_val in the same cycle as start.
    task automatic run(input string nm, input int inj_step, input int rst_step,
                       input bit wr_same, input logic [31:0] wr_val);
        check({nm, " busy before start"}, {31'b0, busy}, 32'h0);
        start = 1'b1;
        if (wr_same) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = wr_val;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int t = 0; t < 23; t++) begin
            for (int i = 0; i < 8; i++) begin
                obs_w[i][t] = w[i];
                obs_n[i][t] = n[i];
                check($sformatf("%s west%0d t%0d", nm, i, t), w[i], exp_w(i, t));
                check($sformatf("%s north%0d t%0d", nm, i, t), n[i], exp_n(i, t));
            end
            check($sformatf("%s busy t%0d", nm, t), {31'b0, busy}, 32'h1);
            check($sformatf("%s done t%0d", nm, t), {31'b0, done}, 32'h0);
            if (t == inj_step) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 32'hDEAD;
                start = 1'b1;
            end
            if (t == rst_step) rst = 1'b0;
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            if (t == rst_step) begin
                check_idle_outputs({nm, " after reset"});
                check({nm, " busy after reset"}, {31'b0, busy}, 32'h0);
                check({nm, " done after reset"}, {31'b0, done}, 32'h0);
                rst = 1'b1;
                return;
            end
        end
        check({nm, " done pulse"}, {31'b0, done}, 32'h1);
        check({nm, " busy at done"}, {31'b0, busy}, 32'h0);
        check_idle_outputs({nm, " at done"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // A[i][k] = 16i+k+1, B = identity.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++)
                wr(1'b0, i*8 + k, 32'(16*i + k + 1));
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++)
                wr(1'b1, i*8 + k, (i == k) ? 32'h1 : 32'h0);

        run("r1", -1, -1, 1'b0, 32'h0);
        // west5: zero at 0..4, 0x51..0x58 at 5..12, zero at 13..14.
        for (int t = 0; t < 5; t++) check($sformatf("r1 hand west5 t%0d", t), obs_w[5][t], 32'h0);
        for (int t = 5; t < 13; t++)
            check($sformatf("r1 hand west5 t%0d", t), obs_w[5][t], 32'h51 + 32'(t - 5));
        check("r1 hand west5 t13", obs_w[5][13], 32'h0);
        check("r1 hand west5 t14", obs_w[5][14], 32'h0);
        // north3 carries B[t-3][3]; identity places the single 1 at t=6.
        for (int t = 0; t < 15; t++)
            check($sformatf("r1 hand north3 t%0d", t), obs_n[3][t], (t == 6) ? 32'h1 : 32'h0);

        // Start again in the done cycle: identical stream.
        run("r2", -1, -1, 1'b0, 32'h0);
        check("r2 hand west5 t5", obs_w[5][5], 32'h51);

        // B[k][j] = 0x100k + j.
        @(negedge clk);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                wr(1'b1, k*8 + j, 32'h100 * 32'(k) + 32'(j));

        // Busy-time write of A[0]=0xDEAD and start at step 4 are ignored.
        run("r3", 4, -1, 1'b0, 32'h0);
        for (int t = 0; t < 7; t++) check($sformatf("r3 hand north7 t%0d", t), obs_n[7][t], 32'h0);
        check("r3 hand north7 t7", obs_n[7][7], 32'h007);
        check("r3 hand north7 t10", obs_n[7][10], 32'h307);
        check("r3 hand north7 t14", obs_n[7][14], 32'h707);
        check("r3 hand north0 drain", obs_n[0][18], 32'h0);

        run("r4", -1, -1, 1'b0, 32'h0);
        check("r4 hand west0 t0 original", obs_w[0][0], 32'h1);

        // Reset at step 6 aborts with no done; buffers are retained.
        run("r5", -1, 6, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("post-abort done c%0d", c), {31'b0, done}, 32'h0);
            check($sformatf("post-abort busy c%0d", c), {31'b0, busy}, 32'h0);
            @(negedge clk);
        end
        run("r6", -1, -1, 1'b0, 32'h0);
        check("r6 hand west7 t14", obs_w[7][14], 32'h78);

        // Write A[0]=0x99 together with start: this run sees the old word.
        run("r7", -1, -1, 1'b1, 32'h99);
        check("r7 hand west0 t0 old", obs_w[0][0], 32'h1);
        ref_a[0] = 32'h99;
        run("r8", -1, -1, 1'b0, 32'h0);
        check("r8 hand west0 t0 new", obs_w[0][0], 32'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
